// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Accumulator-side sequencer for a 3-bit-op ALU.
//
// The block owns the AC, E and DR registers and the N/Z/OVF status flags. It
// accepts one AC-class instruction at a time. For memory-reference ops it reads
// the DR operand over a req/ack port. It then drives the ALU operands and the
// op select, writes the result back, and pulses done (with skip) on
// completion. Undefined opcodes pulse illegal. A read that is never
// acknowledged pulses fault.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   instr_valid/ready       instruction handshake; ready only in IDLE
//   instr_op, instr_addr    opcode and operand address
//   mem_req/addr            read request, held until ack or timeout
//   mem_ack/rdata           read data strobe and data
//   alu_ac/dr/e/op          operands and op select driven to the ALU
//   alu_result/co/ovf       ALU outputs
//   ac, e                   architectural registers
//   flag_n/z/ovf            status flags
//   done, skip              completion pulse; skip is valid only with done
//   illegal, fault          undefined-opcode and read-timeout pulses
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 12,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  alu_ac,
  output logic [WIDTH-1:0]  alu_dr,
  output logic              alu_e,
  output logic [2:0]        alu_op,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_co,
  input  logic              alu_ovf,
  output logic [WIDTH-1:0]  ac,
  output logic              e,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_ovf,
  output logic              done,
  output logic              skip,
  output logic              illegal,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC
  } state_t;

  // Instruction opcodes; 4'hE and 4'hF are undefined.
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_CMA = 4'h3;
  localparam logic [3:0] OP_CIR = 4'h4;
  localparam logic [3:0] OP_CIL = 4'h5;
  localparam logic [3:0] OP_CLA = 4'h6;
  localparam logic [3:0] OP_CLE = 4'h7;
  localparam logic [3:0] OP_CME = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_SZA = 4'hA;
  localparam logic [3:0] OP_SNA = 4'hB;
  localparam logic [3:0] OP_SZE = 4'hC;
  localparam logic [3:0] OP_SPA = 4'hD;

  // ALU select encodings.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_XFER = 3'b010;
  localparam logic [2:0] ALU_COMP = 3'b011;
  localparam logic [2:0] ALU_SHR  = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;

  // The counter must be able to hold MEM_TIMEOUT-1.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WIDTH-1:0]    dr_q;
  logic [CNT_W-1:0]    cnt_q;

  // Decoded views of the offered opcode.
  logic op_is_mem, op_is_illegal;
  logic read_timeout;

  // Writeback values computed during EXEC.
  logic             ac_wr;
  logic [WIDTH-1:0] ac_new;
  logic             e_new;
  logic             ovf_new;
  logic             skip_new;

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_AND:  return ALU_AND;
      OP_LDA:  return ALU_XFER;
      OP_CMA:  return ALU_COMP;
      OP_CIR:  return ALU_SHR;
      OP_CIL:  return ALU_SHL;
      default: return ALU_ADD;   // ADD, INC, and ops that ignore the ALU
    endcase
  endfunction

  assign op_is_mem     = (instr_op <= OP_LDA);
  assign op_is_illegal = (instr_op > OP_SPA);
  assign read_timeout  = (state_q == S_READ) && !mem_ack && (cnt_q == CNT_LAST);

  assign mem_addr = addr_q;
  assign alu_ac   = ac;
  assign alu_e    = e;
  // INC reuses the adder with a constant second operand.
  assign alu_dr   = (op_q == OP_INC) ? WIDTH'(1) : dr_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples its pre-edge value, regardless of the order of statements or
  // processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake/ALU outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default at the top.
  // A path that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    alu_op      = ALU_ADD;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && !op_is_illegal)
          state_d = op_is_mem ? S_READ : S_EXEC;
      end
      S_READ: begin
        mem_req = 1'b1;
        if (mem_ack)           state_d = S_EXEC;
        else if (read_timeout) state_d = S_IDLE;
      end
      S_EXEC: begin
        alu_op  = alu_sel(op_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Writeback decode. These values are meaningful only in EXEC, where alu_op
  // reflects the latched opcode. Skip tests use pre-instruction AC/E.
  // ---------------------------------------------------------------------------
  always_comb begin
    ac_wr    = 1'b0;
    ac_new   = alu_result;
    e_new    = e;
    ovf_new  = 1'b0;
    skip_new = 1'b0;
    case (op_q)
      OP_ADD: begin
        ac_wr   = 1'b1;
        e_new   = alu_co;
        ovf_new = alu_ovf;
      end
      OP_AND, OP_LDA, OP_CMA: ac_wr = 1'b1;
      OP_CIR: begin
        ac_wr = 1'b1;
        e_new = ac[0];
      end
      OP_CIL: begin
        ac_wr = 1'b1;
        e_new = ac[WIDTH-1];
      end
      OP_INC: begin
        ac_wr   = 1'b1;
        ovf_new = alu_ovf;
      end
      OP_CLA: begin
        ac_wr  = 1'b1;
        ac_new = '0;
      end
      OP_CLE:  e_new    = 1'b0;
      OP_CME:  e_new    = ~e;
      OP_SZA:  skip_new = (ac == '0);
      OP_SNA:  skip_new = ac[WIDTH-1];
      OP_SZE:  skip_new = ~e;
      OP_SPA:  skip_new = ~ac[WIDTH-1];
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      addr_q   <= '0;
      dr_q     <= '0;
      cnt_q    <= '0;
      ac       <= '0;
      e        <= 1'b0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
      flag_ovf <= 1'b0;
      done     <= 1'b0;
      skip     <= 1'b0;
      illegal  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      // All status outputs are single-cycle pulses unless re-asserted below.
      done    <= 1'b0;
      skip    <= 1'b0;
      illegal <= 1'b0;
      fault   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_q    <= instr_op;
            addr_q  <= instr_addr;
            cnt_q   <= '0;
            illegal <= op_is_illegal;
          end
        end
        S_READ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_ack)           dr_q  <= mem_rdata;
          else if (read_timeout) fault <= 1'b1;
        end
        S_EXEC: begin
          done <= 1'b1;
          skip <= skip_new;
          e    <= e_new;
          if (ac_wr) begin
            ac       <= ac_new;
            flag_z   <= (ac_new == '0);
            flag_n   <= ac_new[WIDTH-1];
            flag_ovf <= ovf_new;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Bench for alu_sequencer. The stimulus process issues directed
// instructions. For each one it pushes a hand-computed expected completion
// record into a scoreboard queue. A monitor pops a record whenever the DUT
// pulses done, illegal or fault, and compares against it. A memory responder
// acks each read on a programmable READ cycle. A behavioural ALU closes the
// loop.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int WIDTH       = 16;
  localparam int ADDR_W      = 12;
  localparam int MEM_TIMEOUT = 8;

  localparam logic [1:0] K_DONE    = 2'd0;
  localparam logic [1:0] K_ILLEGAL = 2'd1;
  localparam logic [1:0] K_FAULT   = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic [WIDTH-1:0]  ac;
    logic              e;
    logic              n;
    logic              z;
    logic              ovf;
    logic              skip;
    int                lat;
    int                req;
    logic [ADDR_W-1:0] addr;
    int                t0;
    int                req_base;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [3:0]        instr_op = '0;
  logic [ADDR_W-1:0] instr_addr = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [WIDTH-1:0]  mem_rdata = '0;
  logic [WIDTH-1:0]  alu_ac, alu_dr, alu_result;
  logic              alu_e, alu_co, alu_ovf;
  logic [2:0]        alu_op;
  logic [WIDTH-1:0]  ac;
  logic              e, flag_n, flag_z, flag_ovf;
  logic              done, skip, illegal, fault;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   completions = 0;
  int   req_total = 0;
  int   req_cur = 0;
  int   ack_k = 0;
  logic [WIDTH-1:0]  ack_data = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  exp_t sb[$];

  alu_sequencer #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_addr(instr_addr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_e(alu_e), .alu_op(alu_op),
    .alu_result(alu_result), .alu_co(alu_co), .alu_ovf(alu_ovf),
    .ac(ac), .e(e), .flag_n(flag_n), .flag_z(flag_z), .flag_ovf(flag_ovf),
    .done(done), .skip(skip), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU.
  always_comb begin
    logic [WIDTH:0] sum;
    sum        = {1'b0, alu_ac} + {1'b0, alu_dr};
    alu_result = '0;
    alu_co     = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_result = sum[WIDTH-1:0];
        alu_co     = sum[WIDTH];
        alu_ovf    = (alu_ac[WIDTH-1] == alu_dr[WIDTH-1]) &&
                     (sum[WIDTH-1] != alu_ac[WIDTH-1]);
      end
      3'b001:  alu_result = alu_ac & alu_dr;
      3'b010:  alu_result = alu_dr;
      3'b011:  alu_result = ~alu_ac;
      3'b100:  alu_result = {alu_e, alu_ac[WIDTH-1:1]};
      3'b101:  alu_result = {alu_ac[WIDTH-2:0], alu_e};
      default: alu_result = '0;
    endcase
  end

  // Memory responder: acks on the ack_k-th cycle of mem_req (0 = never).
  always @(negedge clk) begin
    if (mem_req) begin
      req_total = req_total + 1;
      req_cur   = req_cur + 1;
      last_addr = mem_addr;
      if (req_cur == ack_k) begin
        mem_ack   = 1'b1;
        mem_rdata = ack_data;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
      end
    end else begin
      req_cur = 0;
      mem_ack = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected record per completion pulse.
  always @(negedge clk) begin
    if (rst_n && (done || illegal || fault)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, fault, illegal, done}, 32'd0);
      end else begin
        exp_t r;
        logic [2:0] kind_oh;
        r = sb.pop_front();
        kind_oh = (r.kind == K_DONE) ? 3'b001 : (r.kind == K_ILLEGAL) ? 3'b010 : 3'b100;
        check("pulse_kind", {29'd0, fault, illegal, done}, {29'd0, kind_oh});
        check("ac", {16'd0, ac}, {16'd0, r.ac});
        check("e", {31'd0, e}, {31'd0, r.e});
        check("flags_nzo", {29'd0, flag_n, flag_z, flag_ovf}, {29'd0, r.n, r.z, r.ovf});
        if (r.kind == K_DONE) check("skip", {31'd0, skip}, {31'd0, r.skip});
        check("latency", cyc - r.t0, r.lat);
        check("mem_req_cycles", req_total - r.req_base, r.req);
        if (r.req > 0) check("mem_addr", {20'd0, last_addr}, {20'd0, r.addr});
      end
      completions = completions + 1;
    end
  end

  // Issue one instruction and wait (bounded) for its completion pulse.
  // Called half a cycle after a falling edge so the accept edge is cyc+1.
  task automatic issue(input logic [3:0] op, input logic [ADDR_W-1:0] addr,
                       input int k, input logic [WIDTH-1:0] rdata,
                       input logic [1:0] kind, input logic [WIDTH-1:0] x_ac,
                       input logic x_e, input logic x_n, input logic x_z,
                       input logic x_ovf, input logic x_skip,
                       input int lat, input int req);
    exp_t r;
    int   target;
    bit   seen;
    check("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    ack_k      = k;
    ack_data   = rdata;
    r.kind = kind; r.ac = x_ac; r.e = x_e; r.n = x_n; r.z = x_z; r.ovf = x_ovf;
    r.skip = x_skip; r.lat = lat; r.req = req; r.addr = addr;
    r.t0 = cyc; r.req_base = req_total;
    sb.push_back(r);
    target      = completions + 1;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_addr  = addr;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (completions >= target) seen = 1'b1;
    end
    if (!seen) begin
      check("completion_timeout", 32'd0, 32'd1);
      sb.delete();
      completions = target;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ac", {16'd0, ac}, 32'd0);
    check("rst_e_flags", {28'd0, e, flag_n, flag_z, flag_ovf}, 32'd0);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_pulses", {28'd0, done, skip, illegal, fault}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    #2;

    //     op     addr    k  rdata     kind       ac       e  n  z  o  s lat req
    issue(4'h2, 12'h005, 3, 16'h8001, K_DONE,    16'h8001, 0, 1, 0, 0, 0, 5, 3);  // LDA
    issue(4'h2, 12'h123, 1, 16'h0001, K_DONE,    16'h0001, 0, 0, 0, 0, 0, 3, 1);  // LDA
    issue(4'h0, 12'h010, 1, 16'hFFFF, K_DONE,    16'h0000, 1, 0, 1, 0, 0, 3, 1);  // ADD wrap
    issue(4'h2, 12'h020, 2, 16'h7FFF, K_DONE,    16'h7FFF, 1, 0, 0, 0, 0, 4, 2);  // LDA
    issue(4'h9, 12'h000, 0, 16'h0000, K_DONE,    16'h8000, 1, 1, 0, 1, 0, 2, 0);  // INC ovf
    issue(4'h7, 12'h000, 0, 16'h0000, K_DONE,    16'h8000, 0, 1, 0, 1, 0, 2, 0);  // CLE
    issue(4'h5, 12'h000, 0, 16'h0000, K_DONE,    16'h0000, 1, 0, 1, 0, 0, 2, 0);  // CIL
    issue(4'h2, 12'h0FF, 1, 16'h0001, K_DONE,    16'h0001, 1, 0, 0, 0, 0, 3, 1);  // LDA
    issue(4'h4, 12'h000, 0, 16'h0000, K_DONE,    16'h8000, 1, 1, 0, 0, 0, 2, 0);  // CIR
    issue(4'h6, 12'h000, 0, 16'h0000, K_DONE,    16'h0000, 1, 0, 1, 0, 0, 2, 0);  // CLA
    issue(4'hA, 12'h000, 0, 16'h0000, K_DONE,    16'h0000, 1, 0, 1, 0, 1, 2, 0);  // SZA
    issue(4'hC, 12'h000, 0, 16'h0000, K_DONE,    16'h0000, 1, 0, 1, 0, 0, 2, 0);  // SZE
    issue(4'h8, 12'h000, 0, 16'h0000, K_DONE,    16'h0000, 0, 0, 1, 0, 0, 2, 0);  // CME
    issue(4'hC, 12'h000, 0, 16'h0000, K_DONE,    16'h0000, 0, 0, 1, 0, 1, 2, 0);  // SZE
    issue(4'h2, 12'h444, 1, 16'h0004, K_DONE,    16'h0004, 0, 0, 0, 0, 0, 3, 1);  // LDA
    issue(4'hB, 12'h000, 0, 16'h0000, K_DONE,    16'h0004, 0, 0, 0, 0, 0, 2, 0);  // SNA
    issue(4'hD, 12'h000, 0, 16'h0000, K_DONE,    16'h0004, 0, 0, 0, 0, 1, 2, 0);  // SPA
    issue(4'hF, 12'h000, 0, 16'h0000, K_ILLEGAL, 16'h0004, 0, 0, 0, 0, 0, 1, 0);  // illegal
    issue(4'h2, 12'h7FF, 1, 16'h7FFF, K_DONE,    16'h7FFF, 0, 0, 0, 0, 0, 3, 1);  // LDA
    issue(4'h9, 12'h000, 0, 16'h0000, K_DONE,    16'h8000, 0, 1, 0, 1, 0, 2, 0);  // INC ovf
    issue(4'h1, 12'hABC, 2, 16'hC00F, K_DONE,    16'h8000, 0, 1, 0, 0, 0, 4, 2);  // AND clears ovf
    issue(4'h3, 12'h000, 0, 16'h0000, K_DONE,    16'h7FFF, 0, 0, 0, 0, 0, 2, 0);  // CMA
    issue(4'h0, 12'h001, 1, 16'h0001, K_DONE,    16'h8000, 0, 1, 0, 1, 0, 3, 1);  // ADD ovf
    issue(4'hE, 12'h000, 0, 16'h0000, K_ILLEGAL, 16'h8000, 0, 1, 0, 1, 0, 1, 0);  // illegal
    issue(4'h0, 12'h3A5, 0, 16'h0000, K_FAULT,   16'h8000, 0, 1, 0, 1, 0,
          MEM_TIMEOUT + 1, MEM_TIMEOUT);                                          // timeout

    // Reset in the middle of a READ: the op is discarded, and mem_req drops at once.
    ack_k       = 0;
    instr_valid = 1'b1;
    instr_op    = 4'h0;
    instr_addr  = 12'h055;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_read_req_before", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_read_req_dropped", {31'd0, mem_req}, 32'd0);
    check("mid_read_idle_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_read_ac_cleared", {16'd0, ac}, 32'd0);
    check("mid_read_pulses", {28'd0, done, skip, illegal, fault}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    // No stray fault or done may follow the discarded op.
    repeat (MEM_TIMEOUT + 4) @(negedge clk);
    #2;
    check("post_reset_queue_empty", sb.size(), 32'd0);
    issue(4'h2, 12'h00A, 2, 16'h1234, K_DONE,    16'h1234, 0, 0, 0, 0, 0, 4, 2);  // LDA recovery

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
